// File: rtl/sm83_bus_ctrl.sv
// SM83 memory-side bus controller: decodes CPU accesses to bootrom, lockout register, HRAM, IE and cartridge.
// Optional build macro SM83_BOOT_SKIP_EN: start with the bootrom already locked out and never selectable.
module sm83_bus_ctrl #(
  parameter int unsigned BOOT_SIZE = 256,
  parameter logic [15:0] LOCK_ADDR = 16'hFF50,
  parameter logic [15:0] HRAM_BASE = 16'hFF80,
  parameter logic [15:0] IE_ADDR   = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_cs,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rdata_vld,
  output logic [7:0]  rom_addr,
  output logic        rom_en,
  input  logic [7:0]  rom_data,
  output logic [15:0] cart_addr,
  output logic        cart_rd,
  output logic        cart_wr,
  output logic [7:0]  cart_wdata,
  input  logic [7:0]  cart_rdata,
  output logic        boot_active,
  output logic [4:0]  ie_reg
);

  typedef enum logic [2:0] {SEL_ROM, SEL_LOCK, SEL_HRAM, SEL_IE, SEL_CART} sel_t;

`ifdef SM83_BOOT_SKIP_EN
  localparam bit BOOT_SKIP = 1'b1;
`else
  localparam bit BOOT_SKIP = 1'b0;
`endif

  localparam logic [16:0] BOOT_END   = 17'(BOOT_SIZE);
  localparam int          HRAM_DEPTH = int'(16'hFFFF - HRAM_BASE);

  sel_t       sel, sel_q;
  logic       is_rd, is_wr, rd_q;
  logic [6:0] hram_idx;
  logic [7:0] hram_q;
  logic [7:0] hram [HRAM_DEPTH];

  // A simultaneous rd+wr is a write; the read half is dropped.
  assign is_wr = cpu_cs && cpu_wr && !rst;
  assign is_rd = cpu_cs && cpu_rd && !cpu_wr && !rst;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sel = SEL_CART;
    if (!BOOT_SKIP && boot_active && ({1'b0, cpu_addr} < BOOT_END)) sel = SEL_ROM;
    else if (cpu_addr == LOCK_ADDR)                                 sel = SEL_LOCK;
    else if (cpu_addr >= HRAM_BASE && cpu_addr != 16'hFFFF)         sel = SEL_HRAM;
    else if (cpu_addr == IE_ADDR)                                   sel = SEL_IE;
  end

  assign hram_idx   = 7'(cpu_addr - HRAM_BASE);
  assign rom_addr   = cpu_addr[7:0];
  assign rom_en     = !BOOT_SKIP && is_rd && (sel == SEL_ROM);
  assign cart_addr  = cpu_addr;
  assign cart_wdata = cpu_wdata;
  assign cart_rd    = is_rd && (sel == SEL_CART);
  assign cart_wr    = is_wr && (sel == SEL_CART);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      boot_active <= !BOOT_SKIP;
      ie_reg      <= 5'd0;
      rd_q        <= 1'b0;
      sel_q       <= SEL_CART;
    end else begin
      rd_q <= is_rd;
      if (is_rd) sel_q <= sel;
      if (is_wr && sel == SEL_LOCK && cpu_wdata != 8'h00 && !BOOT_SKIP) boot_active <= 1'b0;
      if (is_wr && sel == SEL_IE) ie_reg <= cpu_wdata[4:0];
    end
  end

  // NOTE: HRAM is a plain RAM array with no reset so it maps onto memory macros; contents survive rst.
  always_ff @(posedge clk) begin
    if (is_wr && sel == SEL_HRAM) hram[hram_idx] <= cpu_wdata;
    if (is_rd && sel == SEL_HRAM) hram_q <= hram[hram_idx];
  end

  // Gating with rst kills a read response that would otherwise land in a reset cycle.
  assign cpu_rdata_vld = rd_q && !rst;

  always_comb begin
    cpu_rdata = 8'h00;
    if (cpu_rdata_vld) begin
      unique case (sel_q)
        SEL_ROM:  cpu_rdata = rom_data;
        SEL_HRAM: cpu_rdata = hram_q;
        SEL_IE:   cpu_rdata = {3'b111, ie_reg};
        SEL_LOCK: cpu_rdata = {7'h7F, ~boot_active};
        default:  cpu_rdata = cart_rdata;
      endcase
    end
  end

endmodule

// File: tb/tb_sm83_bus_ctrl.sv
// Directed self-checking bench for sm83_bus_ctrl (default build, bootrom enabled).
module tb_sm83_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_cs, cpu_rd, cpu_wr;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_rdata_vld;
  logic [7:0]  rom_addr, rom_data;
  logic        rom_en;
  logic [15:0] cart_addr;
  logic        cart_rd, cart_wr;
  logic [7:0]  cart_wdata, cart_rdata;
  logic        boot_active;
  logic [4:0]  ie_reg;

  int n_checks = 0;
  int n_fail   = 0;

  sm83_bus_ctrl dut (
    .clk(clk), .rst(rst), .cpu_cs(cpu_cs), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_rdata_vld(cpu_rdata_vld), .rom_addr(rom_addr), .rom_en(rom_en),
    .rom_data(rom_data), .cart_addr(cart_addr), .cart_rd(cart_rd), .cart_wr(cart_wr),
    .cart_wdata(cart_wdata), .cart_rdata(cart_rdata), .boot_active(boot_active),
    .ie_reg(ie_reg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cs, input logic rd, input logic wr,
                       input logic [15:0] addr, input logic [7:0] wdata);
    cpu_cs    = cs;
    cpu_rd    = rd;
    cpu_wr    = wr;
    cpu_addr  = addr;
    cpu_wdata = wdata;
  endtask

  initial begin
    rst = 1'b1;
    rom_data = 8'h00;
    cart_rdata = 8'h00;
    drive(0, 0, 0, 16'h0000, 8'h00);
    step();
    drive(1, 1, 0, 16'h0000, 8'h00);
    #1;
    check("rom_en_in_rst", 16'(rom_en), 16'h0);
    check("cart_rd_in_rst", 16'(cart_rd), 16'h0);
    step();
    rst = 1'b0;
    drive(0, 0, 0, 16'h0000, 8'h00);
    #1;
    check("vld_after_rst", 16'(cpu_rdata_vld), 16'h0);
    check("rdata_after_rst", 16'(cpu_rdata), 16'h00);
    check("boot_active_rst", 16'(boot_active), 16'h1);
    check("ie_reg_rst", 16'(ie_reg), 16'h00);

    // Bootrom read at 0x0000.
    step();
    rom_data = 8'h31;
    drive(1, 1, 0, 16'h0000, 8'h00);
    #1;
    check("rom_en_read", 16'(rom_en), 16'h1);
    check("rom_addr_0", 16'(rom_addr), 16'h00);
    check("cart_rd_rom", 16'(cart_rd), 16'h0);
    step();
    drive(1, 1, 0, 16'h0005, 8'h00);
    #1;
    check("rom_vld", 16'(cpu_rdata_vld), 16'h1);
    check("rom_rdata", 16'(cpu_rdata), 16'h31);
    check("rom_addr_5", 16'(rom_addr), 16'h05);

    // ROM write ignored, no cartridge strobe.
    step();
    drive(1, 0, 1, 16'h0010, 8'h99);
    #1;
    check("rom_wr_no_cart", 16'(cart_wr), 16'h0);
    check("rom_wr_no_rom_en", 16'(rom_en), 16'h0);

    // Zero write to lockout has no effect.
    step();
    drive(1, 0, 1, 16'hFF50, 8'h00);
    #1;
    check("lock_wr_no_cart", 16'(cart_wr), 16'h0);
    step();
    drive(1, 1, 0, 16'hFF50, 8'h00);
    #1;
    check("lock_zero_boot", 16'(boot_active), 16'h1);
    step();
    drive(0, 0, 0, 16'h0000, 8'h00);
    #1;
    check("lock_rd_fe", 16'(cpu_rdata), 16'hFE);

    // Nonzero write locks out the bootrom; 0x0000 now goes to the cartridge.
    step();
    drive(1, 0, 1, 16'hFF50, 8'h01);
    step();
    cart_rdata = 8'hC3;
    drive(1, 1, 0, 16'h0000, 8'h00);
    #1;
    check("boot_locked", 16'(boot_active), 16'h0);
    check("cart_rd_0000", 16'(cart_rd), 16'h1);
    check("rom_en_locked", 16'(rom_en), 16'h0);
    check("cart_addr_0000", cart_addr, 16'h0000);
    step();
    drive(1, 1, 0, 16'hFF50, 8'h00);
    #1;
    check("cart_rdata_c3", 16'(cpu_rdata), 16'hC3);
    step();
    drive(1, 0, 1, 16'hFF50, 8'h00);
    #1;
    check("lock_rd_ff", 16'(cpu_rdata), 16'hFF);
    step();
    drive(0, 0, 0, 16'h0000, 8'h00);
    #1;
    check("lock_sticky", 16'(boot_active), 16'h0);

    // Cartridge write.
    step();
    drive(1, 0, 1, 16'h8000, 8'h77);
    #1;
    check("cart_wr_8000", 16'(cart_wr), 16'h1);
    check("cart_wdata_77", 16'(cart_wdata), 16'h77);

    // HRAM writes then back-to-back reads.
    step();
    drive(1, 0, 1, 16'hFF80, 8'hAA);
    #1;
    check("hram_wr_no_cart", 16'(cart_wr), 16'h0);
    step();
    drive(1, 0, 1, 16'hFFFE, 8'h55);
    step();
    drive(1, 1, 0, 16'hFF80, 8'h00);
    #1;
    check("hram_rd_no_cart", 16'(cart_rd), 16'h0);
    step();
    drive(1, 1, 0, 16'hFFFE, 8'h00);
    #1;
    check("hram_vld_a", 16'(cpu_rdata_vld), 16'h1);
    check("hram_rd_aa", 16'(cpu_rdata), 16'hAA);
    step();
    drive(1, 0, 1, 16'hFF81, 8'h12);
    #1;
    check("hram_vld_b", 16'(cpu_rdata_vld), 16'h1);
    check("hram_rd_55", 16'(cpu_rdata), 16'h55);
    // Read directly after a write to the same location sees the new value.
    step();
    drive(1, 1, 0, 16'hFF81, 8'h00);
    step();
    drive(0, 0, 0, 16'h0000, 8'h00);
    #1;
    check("hram_raw_12", 16'(cpu_rdata), 16'h12);

    // IE register.
    step();
    drive(1, 0, 1, 16'hFFFF, 8'hFF);
    #1;
    check("ie_wr_no_cart", 16'(cart_wr), 16'h0);
    step();
    drive(1, 1, 0, 16'hFFFF, 8'h00);
    #1;
    check("ie_reg_1f", 16'(ie_reg), 16'h1F);
    step();
    drive(1, 0, 1, 16'hFFFF, 8'h0A);
    #1;
    check("ie_rd_ff", 16'(cpu_rdata), 16'hFF);
    step();
    drive(1, 1, 0, 16'hFFFF, 8'h00);
    step();
    drive(1, 1, 1, 16'hFF80, 8'h3C);
    #1;
    check("ie_rd_ea", 16'(cpu_rdata), 16'hEA);
    check("rdwr_no_cart_wr", 16'(cart_wr), 16'h0);
    step();
    drive(1, 1, 0, 16'hFF80, 8'h00);
    #1;
    check("rdwr_no_vld", 16'(cpu_rdata_vld), 16'h0);
    step();
    drive(0, 0, 0, 16'h0000, 8'h00);
    #1;
    check("rdwr_wrote_3c", 16'(cpu_rdata), 16'h3C);

    // Reset right after an issued read suppresses its response.
    step();
    drive(1, 1, 0, 16'hFFFE, 8'h00);
    step();
    rst = 1'b1;
    drive(0, 0, 0, 16'h0000, 8'h00);
    #1;
    check("rst_kills_vld", 16'(cpu_rdata_vld), 16'h0);
    step();
    rst = 1'b0;
    #1;
    check("rst_boot_active", 16'(boot_active), 16'h1);
    check("rst_ie_reg", 16'(ie_reg), 16'h00);
    check("rst_vld_low", 16'(cpu_rdata_vld), 16'h0);
    step();
    drive(1, 1, 0, 16'hFF80, 8'h00);
    step();
    drive(0, 0, 0, 16'h0000, 8'h00);
    #1;
    check("hram_retained", 16'(cpu_rdata), 16'h3C);
    check("hram_retained_vld", 16'(cpu_rdata_vld), 16'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
